// File: rtl/execute_memory.sv
// EX/MEM pipeline register with a two-state dcache request FSM.
// Build with LLSC_EN defined to add the LL/SC link register; without it atomics act as plain LW/SW.
module execute_memory #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              update,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_alu_out,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic [REG_W-1:0]  ex_wsel,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_to_reg,
  input  logic              ex_mem_wr,
  input  logic              ex_jal_en,
  input  logic              ex_halt,
  input  logic              ex_atomic,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              ccinv,
  input  logic [WORD_W-1:0] ccsnoopaddr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_ready,
  output logic [WORD_W-1:0] alu_out,
  output logic [WORD_W-1:0] npc_out,
  output logic [WORD_W-1:0] rdata_out,
  output logic [REG_W-1:0]  wsel_out,
  output logic              reg_wr_out,
  output logic              mem_to_reg_out,
  output logic              jal_en_out,
  output logic              halt_out
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] alu_q, alu_d, store_q, store_d, npc_q, npc_d, rdata_q, rdata_d;
  logic [REG_W-1:0]  wsel_q, wsel_d;
  logic              reg_wr_q, reg_wr_d, mem_to_reg_q, mem_to_reg_d, mem_wr_q, mem_wr_d;
  logic              jal_q, jal_d, halt_q, halt_d, atomic_q, atomic_d;

  logic access, done, capture, sc_fail;

  assign access    = (state_q == ACCESS);
  assign mem_ready = !access || dhit;
  assign done      = access && dhit;
  assign capture   = mem_ready && update && !flush;

`ifdef LLSC_EN
  logic                link_valid_q, link_valid_d;
  logic [WORD_W-1:2]   link_addr_q, link_addr_d;
  logic [WORD_W-1:2]   link_eff_addr;
  logic                ll_done, st_clear, snoop_hit, link_eff_valid, sc_capture;
  logic                unused_lsb;

  assign unused_lsb = ^ccsnoopaddr[1:0];

  // The link as it stands after this cycle's completion and snoop, so an SC
  // captured on the LL's dhit edge (or alongside a snoop) sees the up-to-date link.
  always_comb begin
    ll_done        = done && mem_to_reg_q && atomic_q;
    link_eff_addr  = ll_done ? alu_q[WORD_W-1:2] : link_addr_q;
    st_clear       = done && mem_wr_q && !atomic_q && (alu_q[WORD_W-1:2] == link_addr_q);
    snoop_hit      = ccinv && (ccsnoopaddr[WORD_W-1:2] == link_eff_addr);
    link_eff_valid = (ll_done || (link_valid_q && !st_clear)) && !snoop_hit;
    sc_capture     = capture && ex_atomic && ex_mem_wr;
    sc_fail        = sc_capture &&
                     !(link_eff_valid && (ex_alu_out[WORD_W-1:2] == link_eff_addr));
    link_valid_d   = link_eff_valid && !sc_capture;
    link_addr_d    = link_eff_addr;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end
`else
  logic unused_snoop;

  assign unused_snoop = ^{ccinv, ccsnoopaddr};
  assign sc_fail      = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    store_d      = store_q;
    npc_d        = npc_q;
    rdata_d      = rdata_q;
    wsel_d       = wsel_q;
    reg_wr_d     = reg_wr_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_wr_d     = mem_wr_q;
    jal_d        = jal_q;
    halt_d       = halt_q;
    atomic_d     = atomic_q;

    if (mem_ready) begin
      state_d = IDLE;
      if (flush) begin
        alu_d        = '0;
        store_d      = '0;
        npc_d        = '0;
        rdata_d      = '0;
        wsel_d       = '0;
        reg_wr_d     = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_wr_d     = 1'b0;
        jal_d        = 1'b0;
        atomic_d     = 1'b0;
      end else if (update) begin
        alu_d        = ex_alu_out;
        store_d      = ex_store_data;
        npc_d        = ex_npc;
        wsel_d       = ex_wsel;
        reg_wr_d     = ex_reg_wr || sc_fail;
        mem_to_reg_d = ex_mem_to_reg;
        mem_wr_d     = ex_mem_wr && !sc_fail;
        jal_d        = ex_jal_en;
        halt_d       = halt_q || ex_halt;
        atomic_d     = ex_atomic;
        if (sc_fail) begin
          rdata_d = '0;
        end
        if (!ex_halt && (ex_mem_to_reg || ex_mem_wr) && !sc_fail) begin
          state_d = ACCESS;
        end
      end
    end

    // The result of the access finishing this edge lands even if a new
    // instruction is captured or flushed on the same edge.
    if (done) begin
      if (mem_to_reg_q) begin
        rdata_d = dmemload;
      end else if (mem_wr_q && atomic_q) begin
        rdata_d = {{(WORD_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      alu_q        <= '0;
      store_q      <= '0;
      npc_q        <= '0;
      rdata_q      <= '0;
      wsel_q       <= '0;
      reg_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_wr_q     <= 1'b0;
      jal_q        <= 1'b0;
      halt_q       <= 1'b0;
      atomic_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_q        <= alu_d;
      store_q      <= store_d;
      npc_q        <= npc_d;
      rdata_q      <= rdata_d;
      wsel_q       <= wsel_d;
      reg_wr_q     <= reg_wr_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_wr_q     <= mem_wr_d;
      jal_q        <= jal_d;
      halt_q       <= halt_d;
      atomic_q     <= atomic_d;
    end
  end

  assign dmemREN        = access && mem_to_reg_q;
  assign dmemWEN        = access && mem_wr_q;
  assign dmemaddr       = alu_q;
  assign dmemstore      = store_q;
  assign alu_out        = alu_q;
  assign npc_out        = npc_q;
  assign rdata_out      = rdata_q;
  assign wsel_out       = wsel_q;
  assign reg_wr_out     = reg_wr_q;
  assign mem_to_reg_out = mem_to_reg_q;
  assign jal_en_out     = jal_q;
  assign halt_out       = halt_q;

endmodule

// File: tb/tb_execute_memory.sv
// Self-checking bench for execute_memory: directed scenarios then random traffic,
// all checked against a transaction-level model of the EX/MEM stage.
module tb_execute_memory;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        update, flush;
  logic [31:0] ex_alu_out, ex_store_data, ex_npc;
  logic [4:0]  ex_wsel;
  logic        ex_reg_wr, ex_mem_to_reg, ex_mem_wr, ex_jal_en, ex_halt, ex_atomic;
  logic        dhit;
  logic [31:0] dmemload;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;
  logic        dmemREN, dmemWEN, mem_ready;
  logic [31:0] dmemaddr, dmemstore, alu_out, npc_out, rdata_out;
  logic [4:0]  wsel_out;
  logic        reg_wr_out, mem_to_reg_out, jal_en_out, halt_out;

  execute_memory #(.WORD_W(32), .REG_W(5)) dut (
    .CLK(CLK), .nRST(nRST), .update(update), .flush(flush),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_npc(ex_npc),
    .ex_wsel(ex_wsel), .ex_reg_wr(ex_reg_wr), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_wr(ex_mem_wr), .ex_jal_en(ex_jal_en), .ex_halt(ex_halt),
    .ex_atomic(ex_atomic), .dhit(dhit), .dmemload(dmemload), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_ready(mem_ready),
    .alu_out(alu_out), .npc_out(npc_out), .rdata_out(rdata_out),
    .wsel_out(wsel_out), .reg_wr_out(reg_wr_out), .mem_to_reg_out(mem_to_reg_out),
    .jal_en_out(jal_en_out), .halt_out(halt_out)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_NOP, K_ALU, K_LW, K_SW, K_LL, K_SC, K_JAL, K_HALT} kind_e;

  typedef struct {
    logic [31:0] alu, sdata, npc, rdata;
    logic [4:0]  wsel;
    logic        regwr, m2r, mwr, jal, halt, atomic;
  } stage_t;

  stage_t      m;
  logic        mBusy;
  logic        linkValid;
  logic [31:0] linkAddr;
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic modelReset();
    m         = '{default: '0};
    mBusy     = 1'b0;
    linkValid = 1'b0;
    linkAddr  = '0;
  endtask

  // One clock edge of the stage, applied as ordered events: the outstanding
  // access completes, snoops act on the link, then the latch takes its new contents.
  task automatic modelUpdate();
    logic        ready, done, haveResult, scFail, isSc, keepHalt;
    logic [31:0] result;
    ready      = !mBusy || dhit;
    done       = mBusy && dhit;
    haveResult = 1'b0;
    result     = '0;
    if (done && m.m2r) begin
      haveResult = 1'b1;
      result     = dmemload;
    end else if (done && m.mwr && m.atomic) begin
      haveResult = 1'b1;
      result     = 32'd1;
    end
`ifdef LLSC_EN
    if (done && m.m2r && m.atomic) begin
      linkValid = 1'b1;
      linkAddr  = m.alu;
    end else if (done && m.mwr && !m.atomic && m.alu[31:2] == linkAddr[31:2]) begin
      linkValid = 1'b0;
    end
    if (ccinv && ccsnoopaddr[31:2] == linkAddr[31:2]) linkValid = 1'b0;
`endif
    if (ready) begin
      if (flush) begin
        keepHalt = m.halt;
        m        = '{default: '0};
        m.halt   = keepHalt;
        mBusy    = 1'b0;
      end else if (update) begin
        isSc   = ex_atomic && ex_mem_wr;
        scFail = 1'b0;
`ifdef LLSC_EN
        scFail = isSc && !(linkValid && linkAddr[31:2] == ex_alu_out[31:2]);
        if (isSc) linkValid = 1'b0;
`endif
        m.alu    = ex_alu_out;
        m.sdata  = ex_store_data;
        m.npc    = ex_npc;
        m.wsel   = ex_wsel;
        m.regwr  = ex_reg_wr || scFail;
        m.m2r    = ex_mem_to_reg;
        m.mwr    = ex_mem_wr && !scFail;
        m.jal    = ex_jal_en;
        m.halt   = m.halt || ex_halt;
        m.atomic = ex_atomic;
        if (scFail) m.rdata = '0;
        mBusy = !ex_halt && (ex_mem_to_reg || ex_mem_wr) && !scFail;
      end else begin
        mBusy = 1'b0;
      end
    end
    if (haveResult) m.rdata = result;
  endtask

  task automatic applyStimulus(input kind_e k, input logic [31:0] addr, input logic upd,
                               input logic fl, input logic dh, input logic [31:0] load,
                               input logic inv, input logic [31:0] saddr);
    update        = upd;
    flush         = fl;
    dhit          = dh;
    dmemload      = load;
    ccinv         = inv;
    ccsnoopaddr   = saddr;
    ex_alu_out    = addr;
    ex_store_data = $urandom;
    ex_npc        = $urandom;
    ex_wsel       = 5'($urandom);
    ex_reg_wr     = (k == K_ALU || k == K_LW || k == K_LL || k == K_SC || k == K_JAL);
    ex_mem_to_reg = (k == K_LW || k == K_LL || k == K_HALT);
    ex_mem_wr     = (k == K_SW || k == K_SC);
    ex_atomic     = (k == K_LL || k == K_SC);
    ex_jal_en     = (k == K_JAL);
    ex_halt       = (k == K_HALT);
  endtask

  task automatic checkAll();
    logic expReady;
    expReady = !mBusy || dhit;
    checkOutput("mem_ready", 32'(mem_ready), 32'(expReady));
    checkOutput("dmemREN", 32'(dmemREN), 32'(mBusy && m.m2r));
    checkOutput("dmemWEN", 32'(dmemWEN), 32'(mBusy && m.mwr));
    if (mBusy) checkOutput("dmemaddr", dmemaddr, m.alu);
    if (mBusy && m.mwr) checkOutput("dmemstore", dmemstore, m.sdata);
    checkOutput("alu_out", alu_out, m.alu);
    checkOutput("npc_out", npc_out, m.npc);
    checkOutput("rdata_out", rdata_out, m.rdata);
    checkOutput("wsel_out", 32'(wsel_out), 32'(m.wsel));
    checkOutput("reg_wr_out", 32'(reg_wr_out), 32'(m.regwr));
    checkOutput("mem_to_reg_out", 32'(mem_to_reg_out), 32'(m.m2r));
    checkOutput("jal_en_out", 32'(jal_en_out), 32'(m.jal));
    checkOutput("halt_out", 32'(halt_out), 32'(m.halt));
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic step();
    #1;
    checkAll();
    @(posedge CLK);
    modelUpdate();
    @(negedge CLK);
  endtask

  task automatic doReset();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    nRST = 1'b0;
    #1;
    checkOutput("rst_dmemREN", 32'(dmemREN), 32'd0);
    checkOutput("rst_dmemWEN", 32'(dmemWEN), 32'd0);
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd1);
    checkOutput("rst_alu_out", alu_out, 32'd0);
    checkOutput("rst_npc_out", npc_out, 32'd0);
    checkOutput("rst_rdata_out", rdata_out, 32'd0);
    checkOutput("rst_wsel_out", 32'(wsel_out), 32'd0);
    checkOutput("rst_ctrl", 32'({reg_wr_out, mem_to_reg_out, jal_en_out, halt_out}), 32'd0);
    modelReset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    kind_e       k;
    logic [31:0] addr;
    nRST = 1'b1;
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge CLK);
    doReset();

    $display("[TB] reset in the middle of an access");
    applyStimulus(K_LW, 32'h140, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t1_ren_before", 32'(dmemREN), 32'd1);
    doReset();

    $display("[TB] load with three-cycle dcache latency");
    applyStimulus(K_LW, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    step();
    checkOutput("t2_rdata", rdata_out, 32'hDEADBEEF);
    checkOutput("t2_ren_off", 32'(dmemREN), 32'd0);

    $display("[TB] store then back-to-back load");
    applyStimulus(K_SW, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_LW, 32'h204, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t3_hold_addr", alu_out, 32'h200);
    applyStimulus(K_LW, 32'h204, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t3_ren", 32'(dmemREN), 32'd1);
    checkOutput("t3_addr", dmemaddr, 32'h204);
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0);
    step();

    $display("[TB] LL then SC, no snoop");
    applyStimulus(K_LL, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 1'b0, 32'h0);
    step();
    applyStimulus(K_SC, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t4_sc_wen", 32'(dmemWEN), 32'd1);
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t4_sc_rdata", rdata_out, 32'd1);
    applyStimulus(K_SC, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
`ifdef LLSC_EN
    checkOutput("t4_second_sc_wen", 32'(dmemWEN), 32'd0);
`else
    checkOutput("t4_second_sc_wen", 32'(dmemWEN), 32'd1);
`endif
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();

    $display("[TB] LL, snoop invalidate, SC");
    applyStimulus(K_LL, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5A5A5A5A, 1'b0, 32'h0);
    step();
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
    step();
    applyStimulus(K_SC, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t5_reg_wr", 32'(reg_wr_out), 32'd1);
`ifdef LLSC_EN
    checkOutput("t5_sc_wen", 32'(dmemWEN), 32'd0);
    checkOutput("t5_rdata_fail", rdata_out, 32'd0);
`else
    checkOutput("t5_sc_wen", 32'(dmemWEN), 32'd1);
`endif
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();
`ifdef LLSC_EN
    checkOutput("t5_rdata_final", rdata_out, 32'd0);
`else
    checkOutput("t5_rdata_final", rdata_out, 32'd1);
`endif

    $display("[TB] flush against update");
    applyStimulus(K_ALU, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_LW, 32'h600, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t6_bubble_alu", alu_out, 32'h0);
    checkOutput("t6_bubble_ctrl", 32'({reg_wr_out, mem_to_reg_out, jal_en_out}), 32'd0);
    applyStimulus(K_LW, 32'h700, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    applyStimulus(K_ALU, 32'h800, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("t6_stall_alu", alu_out, 32'h700);
    checkOutput("t6_stall_m2r", 32'(mem_to_reg_out), 32'd1);
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      k    = kind_e'($urandom_range(0, 6));
      addr = 32'h300 + 32'(4 * $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(k, addr, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                    mBusy && ($urandom_range(0, 2) == 0), $urandom,
                    ($urandom_range(0, 5) == 0), 32'h300 + 32'(4 * $urandom_range(0, 2)));
      step();
    end

    $display("[TB] halt");
    applyStimulus(K_HALT, 32'h400, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("halt_no_request", 32'(dmemREN), 32'd0);
    checkOutput("halt_set", 32'(halt_out), 32'd1);
    applyStimulus(K_NOP, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checkOutput("halt_sticky", 32'(halt_out), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
